// File: rtl/apa_result_capture.sv
// Sink-side capture for APA_Filter output: strobed {filtered_signal, weight} pairs,
// decimated, buffered in a show-ahead FIFO and drained through a ready/valid port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start after reset
// CAPTURE | taking capture events until NUM_SAMPLES have been counted
// DRAIN   | no new events; waiting for the FIFO to empty
// DONE    | window complete; held until the next start
module apa_result_capture #(
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 6,
  parameter int NUM_SAMPLES = 1000,
  parameter int DECIM       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sample_valid,
  input  logic [DATA_W-1:0]     filtered_signal,
  input  logic [DATA_W-1:0]     weight,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [2*DATA_W-1:0]   rd_data,
  output logic [ADDR_W:0]       fill_level,
  output logic [15:0]           sample_count,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  localparam int                DEC_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DEC_W-1:0]  DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [15:0]       NUM_C    = 16'(NUM_SAMPLES);
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);

  state_t                r_state;
  logic [2*DATA_W-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic [DEC_W-1:0]      r_decim;
  logic [15:0]           r_sample_count;
  logic                  r_overflow;

  logic w_rd_valid;
  logic w_pop;
  logic w_full;
  logic w_take;
  logic w_event;
  logic w_push;

  assign w_rd_valid = (r_count != '0);
  assign w_pop      = w_rd_valid && rd_ready;
  assign w_full     = (r_count == DEPTH_C);
  // Events stop as soon as the window is counted, even before the FSM leaves CAPTURE.
  assign w_take     = (r_state == S_CAPTURE) && sample_valid && (r_sample_count != NUM_C);
  assign w_event    = w_take && (r_decim == DEC_LAST);
  assign w_push     = w_event && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_decim        <= '0;
      r_sample_count <= '0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_sample_count <= '0;
            r_overflow     <= 1'b0;
            r_decim        <= '0;
            r_state        <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (r_sample_count == NUM_C) begin
            r_state <= S_DRAIN;
          end else if (w_take) begin
            r_decim <= w_event ? '0 : r_decim + 1'b1;
            if (w_event) begin
              if (r_sample_count != 16'hFFFF) r_sample_count <= r_sample_count + 16'd1;
              if (!w_push) r_overflow <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (r_count == '0) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while rd_valid is high.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {filtered_signal, weight};
  end

  assign rd_valid     = w_rd_valid;
  assign rd_data      = w_rd_valid ? r_mem[r_rd_ptr] : '0;
  assign fill_level   = r_count;
  assign sample_count = r_sample_count;
  assign busy         = (r_state == S_CAPTURE) || (r_state == S_DRAIN);
  assign done         = (r_state == S_DONE);
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_apa_result_capture.sv
// Directed bench for apa_result_capture: four instances with different window,
// depth and decimation settings, each exercised by its own scenario tasks.
module tb_apa_result_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [4];
  logic        start [4];
  logic        sv    [4];
  logic        rdy   [4];
  logic [15:0] filt  [4];
  logic [15:0] wgt   [4];
  logic        rdv   [4];
  logic [31:0] rdd   [4];
  logic [6:0]  fl    [4];
  logic [15:0] cnt   [4];
  logic        bsy   [4];
  logic        dn    [4];
  logic        ovf   [4];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] got [$];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int P_DEPTH = (g == 1) ? 4 : 64;
    localparam int P_AW    = (g == 1) ? 2 : 6;
    localparam int P_NUM   = (g == 0) ? 4 : (g == 1) ? 6 : (g == 2) ? 2 : 1000;
    localparam int P_DEC   = (g == 2) ? 3 : 1;
    logic [P_AW:0] w_fl;
    apa_result_capture #(
      .DATA_W(16), .DEPTH(P_DEPTH), .ADDR_W(P_AW), .NUM_SAMPLES(P_NUM), .DECIM(P_DEC)
    ) u_dut (
      .clk(clk), .reset(rst[g]), .start(start[g]), .sample_valid(sv[g]),
      .filtered_signal(filt[g]), .weight(wgt[g]), .rd_ready(rdy[g]),
      .rd_valid(rdv[g]), .rd_data(rdd[g]), .fill_level(w_fl), .sample_count(cnt[g]),
      .busy(bsy[g]), .done(dn[g]), .overflow(ovf[g])
    );
    assign fl[g] = 7'(w_fl);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic push_sample(input int i, input logic [15:0] f, input logic [15:0] w);
    sv[i] = 1'b1; filt[i] = f; wgt[i] = w;
    tick();
    sv[i] = 1'b0;
  endtask

  // Drains with rd_ready high, recording every head word until done or the budget expires.
  task automatic collect(input int i, input int maxc);
    got.delete();
    rdy[i] = 1'b1;
    for (int c = 0; c < maxc; c++) begin
      if (dn[i]) break;
      if (rdv[i]) got.push_back(rdd[i]);
      tick();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; sv[i] = 1'b0; rdy[i] = 1'b0;
      filt[i] = '0; wgt[i] = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    tick();
    n_checks++;
    if ({rdv[0], bsy[0], dn[0], ovf[0]} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {rdv[0], bsy[0], dn[0], ovf[0]});
    end
    n_checks++;
    if (rdd[0] !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", rdd[0]); end
    n_checks++;
    if (fl[0] !== 7'd0) begin n_fail++; $display("FAIL reset_fill got %0d exp 0", fl[0]); end
    n_checks++;
    if (cnt[0] !== 16'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", cnt[0]); end
    n_checks++;
    if (fl[1] !== 7'd0) begin n_fail++; $display("FAIL reset_fill_d4 got %0d exp 0", fl[1]); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_q [4];
    int idx = 0;
    exp_q[0] = 32'h000A0001; exp_q[1] = 32'h00140001;
    exp_q[2] = 32'h001E0001; exp_q[3] = 32'h00280001;
    rdy[0] = 1'b1;
    pulse_start(0);
    n_checks++;
    if (bsy[0] !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", bsy[0]); end
    for (int c = 0; c < 20; c++) begin
      if (rdv[0]) begin
        n_checks++;
        if (idx >= 4) begin
          n_fail++; $display("FAIL basic_extra_read got %h exp none", rdd[0]);
        end else if (rdd[0] !== exp_q[idx]) begin
          n_fail++; $display("FAIL basic_data[%0d] got %h exp %h", idx, rdd[0], exp_q[idx]);
        end
        idx++;
      end
      sv[0] = (c < 4); filt[0] = 16'(10 * (c + 1)); wgt[0] = 16'd1;
      tick();
    end
    sv[0] = 1'b0;
    n_checks++;
    if (idx !== 4) begin n_fail++; $display("FAIL basic_reads got %0d exp 4", idx); end
    n_checks++;
    if (cnt[0] !== 16'd4) begin n_fail++; $display("FAIL basic_count got %0d exp 4", cnt[0]); end
    n_checks++;
    if (dn[0] !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b exp 1", dn[0]); end
    n_checks++;
    if (ovf[0] !== 1'b0) begin n_fail++; $display("FAIL basic_overflow got %b exp 0", ovf[0]); end
  endtask

  task automatic test_start_ignored();
    rdy[0] = 1'b0;
    pulse_start(0);
    n_checks++;
    if ({bsy[0], dn[0], cnt[0]} !== {1'b1, 1'b0, 16'd0}) begin
      n_fail++; $display("FAIL done_restart got busy=%b done=%b cnt=%0d exp 1 0 0", bsy[0], dn[0], cnt[0]);
    end
    push_sample(0, 16'd5, 16'd2);
    push_sample(0, 16'd6, 16'd2);
    pulse_start(0);
    n_checks++;
    if ({cnt[0], fl[0], bsy[0]} !== {16'd2, 7'd2, 1'b1}) begin
      n_fail++; $display("FAIL start_in_capture got cnt=%0d fill=%0d busy=%b exp 2 2 1", cnt[0], fl[0], bsy[0]);
    end
    push_sample(0, 16'd7, 16'd2);
    push_sample(0, 16'd8, 16'd2);
    tick();
    pulse_start(0);
    n_checks++;
    if ({cnt[0], fl[0], bsy[0], dn[0]} !== {16'd4, 7'd4, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL start_in_drain got cnt=%0d fill=%0d busy=%b done=%b exp 4 4 1 0",
                         cnt[0], fl[0], bsy[0], dn[0]);
    end
    collect(0, 20);
    n_checks++;
    if (got.size() !== 4) begin n_fail++; $display("FAIL ignore_reads got %0d exp 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      n_checks++;
      if (got[k] !== {16'(5 + k), 16'd2}) begin
        n_fail++; $display("FAIL ignore_data[%0d] got %h exp %h", k, got[k], {16'(5 + k), 16'd2});
      end
    end
    n_checks++;
    if (dn[0] !== 1'b1) begin n_fail++; $display("FAIL ignore_done got %b exp 1", dn[0]); end
  endtask

  task automatic test_overflow();
    rdy[1] = 1'b0;
    pulse_start(1);
    for (int k = 1; k <= 6; k++) begin
      sv[1] = 1'b1; filt[1] = 16'(k); wgt[1] = 16'h0100;
      tick();
    end
    sv[1] = 1'b0;
    n_checks++;
    if (fl[1] !== 7'd4) begin n_fail++; $display("FAIL ovf_fill got %0d exp 4", fl[1]); end
    n_checks++;
    if (ovf[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", ovf[1]); end
    n_checks++;
    if (cnt[1] !== 16'd6) begin n_fail++; $display("FAIL ovf_count got %0d exp 6", cnt[1]); end
    collect(1, 30);
    n_checks++;
    if (got.size() !== 4) begin n_fail++; $display("FAIL ovf_reads got %0d exp 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      n_checks++;
      if (got[k] !== {16'(k + 1), 16'h0100}) begin
        n_fail++; $display("FAIL ovf_data[%0d] got %h exp %h", k, got[k], {16'(k + 1), 16'h0100});
      end
    end
    n_checks++;
    if (dn[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_done got %b exp 1", dn[1]); end
  endtask

  task automatic test_full_push_pop();
    rdy[1] = 1'b0;
    pulse_start(1);
    n_checks++;
    if ({ovf[1], cnt[1], bsy[1]} !== {1'b0, 16'd0, 1'b1}) begin
      n_fail++; $display("FAIL restart_clear got ovf=%b cnt=%0d busy=%b exp 0 0 1", ovf[1], cnt[1], bsy[1]);
    end
    for (int k = 0; k < 4; k++) push_sample(1, 16'(16'h11 + k), 16'h000A);
    n_checks++;
    if ({fl[1], ovf[1]} !== {7'd4, 1'b0}) begin
      n_fail++; $display("FAIL fill_to_full got fill=%0d ovf=%b exp 4 0", fl[1], ovf[1]);
    end
    rdy[1] = 1'b1;
    push_sample(1, 16'h0015, 16'h000A);
    rdy[1] = 1'b0;
    n_checks++;
    if ({fl[1], ovf[1], cnt[1]} !== {7'd4, 1'b0, 16'd5}) begin
      n_fail++; $display("FAIL full_push_pop got fill=%0d ovf=%b cnt=%0d exp 4 0 5", fl[1], ovf[1], cnt[1]);
    end
    n_checks++;
    if (rdd[1] !== 32'h0012000A) begin n_fail++; $display("FAIL full_head got %h exp 0012000a", rdd[1]); end
    push_sample(1, 16'h0016, 16'h000A);
    n_checks++;
    if ({fl[1], ovf[1], cnt[1]} !== {7'd4, 1'b1, 16'd6}) begin
      n_fail++; $display("FAIL full_drop got fill=%0d ovf=%b cnt=%0d exp 4 1 6", fl[1], ovf[1], cnt[1]);
    end
    collect(1, 30);
    n_checks++;
    if (got.size() !== 4) begin n_fail++; $display("FAIL full_reads got %0d exp 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      n_checks++;
      if (got[k] !== {16'(16'h12 + k), 16'h000A}) begin
        n_fail++; $display("FAIL full_data[%0d] got %h exp %h", k, got[k], {16'(16'h12 + k), 16'h000A});
      end
    end
  endtask

  task automatic test_decim();
    rdy[2] = 1'b0;
    pulse_start(2);
    for (int k = 1; k <= 6; k++) begin
      sv[2] = 1'b1; filt[2] = 16'(k); wgt[2] = 16'(k);
      tick();
    end
    sv[2] = 1'b0;
    n_checks++;
    if ({cnt[2], fl[2]} !== {16'd2, 7'd2}) begin
      n_fail++; $display("FAIL decim_count got cnt=%0d fill=%0d exp 2 2", cnt[2], fl[2]);
    end
    collect(2, 30);
    n_checks++;
    if (got.size() !== 2) begin
      n_fail++; $display("FAIL decim_reads got %0d exp 2", got.size());
    end else begin
      n_checks++;
      if ({got[0], got[1]} !== {32'h00030003, 32'h00060006}) begin
        n_fail++; $display("FAIL decim_data got %h %h exp 00030003 00060006", got[0], got[1]);
      end
    end
    n_checks++;
    if (dn[2] !== 1'b1) begin n_fail++; $display("FAIL decim_done got %b exp 1", dn[2]); end
  endtask

  task automatic test_reset_mid();
    int reads = 0;
    rdy[3] = 1'b1;
    pulse_start(3);
    for (int k = 0; k < 500; k++) begin
      sv[3] = 1'b1; filt[3] = 16'(k); wgt[3] = 16'(k);
      tick();
    end
    sv[3] = 1'b0;
    n_checks++;
    if (cnt[3] !== 16'd500) begin n_fail++; $display("FAIL mid_count got %0d exp 500", cnt[3]); end
    rst[3] = 1'b1;
    tick();
    rst[3] = 1'b0;
    n_checks++;
    if ({rdv[3], rdd[3], fl[3], cnt[3], bsy[3], dn[3], ovf[3]} !== '0) begin
      n_fail++; $display("FAIL mid_reset got valid=%b data=%h fill=%0d cnt=%0d busy=%b done=%b ovf=%b exp all 0",
                         rdv[3], rdd[3], fl[3], cnt[3], bsy[3], dn[3], ovf[3]);
    end
    pulse_start(3);
    for (int c = 0; c < 1010; c++) begin
      if (rdv[3]) begin
        n_checks++;
        if (rdd[3] !== {16'(reads), ~16'(reads)}) begin
          n_fail++; $display("FAIL window_data[%0d] got %h exp %h", reads, rdd[3], {16'(reads), ~16'(reads)});
        end
        reads++;
      end
      sv[3] = (c < 1000); filt[3] = 16'(c); wgt[3] = ~16'(c);
      tick();
    end
    sv[3] = 1'b0;
    n_checks++;
    if (reads !== 1000) begin n_fail++; $display("FAIL window_reads got %0d exp 1000", reads); end
    n_checks++;
    if ({cnt[3], dn[3], ovf[3]} !== {16'd1000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL window_end got cnt=%0d done=%b ovf=%b exp 1000 1 0", cnt[3], dn[3], ovf[3]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_overflow();
    test_full_push_pop();
    test_decim();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
